// File: rtl/breathe_sequencer.sv
// rtl/breathe_sequencer.sv - RGB breathe/solid PWM sequencer stepping through a colour pattern table
module breathe_sequencer #(
    parameter int NUM_CH             = 3,
    parameter int PWM_BITS           = 8,
    parameter int PERIOD_W           = 24,
    parameter int NUM_PATTERNS       = 6,
    parameter logic [NUM_CH*NUM_PATTERNS-1:0] PATTERN_TABLE = 18'b110_101_011_001_010_100,
    parameter int CYCLES_PER_PATTERN = 2
) (
    input  logic                Sys_Clk0,
    input  logic                Sys_Clk0_Rst_n,
    input  logic                enable_i,
    input  logic [1:0]          mode_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic [PWM_BITS-1:0] brightness_i,
    output logic [NUM_CH-1:0]   led_o,
    output logic [PWM_BITS-1:0] level_o,
    output logic [3:0]          pattern_idx_o,
    output logic                pattern_adv_o
);

    localparam int PH_W  = PWM_BITS + 1;
    localparam int CYC_W = (CYCLES_PER_PATTERN > 1) ? $clog2(CYCLES_PER_PATTERN) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CYCLES_PER_PATTERN - 1);
    localparam logic [3:0]       IDX_LAST = 4'(NUM_PATTERNS - 1);
    localparam logic [1:0]       MODE_SOLID   = 2'b01;
    localparam logic [1:0]       MODE_BREATHE = 2'b10;

    logic [PERIOD_W-1:0] presc_q, presc_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic [3:0]          idx_q, idx_d;
    logic [1:0]          mode_hist_q, mode_hist_d;
    logic [NUM_CH-1:0]   led_q, led_d;
    logic                adv_q, adv_d;

    logic                active, breathe, mode_change;
    logic [PERIOD_W-1:0] per_last;
    logic                presc_done, step_tick, phase_wrap, group_done;
    logic [PWM_BITS-1:0] level, duty;
    logic                pwm_on;
    logic [NUM_CH-1:0]   pattern_bits;

    always_comb begin
        active      = enable_i & ((mode_i == MODE_SOLID) | (mode_i == MODE_BREATHE));
        breathe     = (mode_i == MODE_BREATHE);
        mode_change = (mode_i != mode_hist_q);

        // >= so that shrinking period_i mid-step ends the step immediately
        per_last    = (period_i == '0) ? '0 : period_i - 1'b1;
        presc_done  = (presc_q >= per_last);
        step_tick   = active & ~mode_change & presc_done;
        phase_wrap  = step_tick & breathe & (phase_q == '1);
        group_done  = phase_wrap & (cyc_q == CYC_LAST);

        level  = phase_q[PH_W-1] ? ~phase_q[PWM_BITS-1:0] : phase_q[PWM_BITS-1:0];
        duty   = '0;
        if (active) begin
            duty = breathe ? level : brightness_i;
        end
        pwm_on = (pwm_q < duty);

        pattern_bits = '0;
        for (int k = 0; k < NUM_PATTERNS; k++) begin
            if (idx_q == 4'(k)) begin
                pattern_bits = PATTERN_TABLE[k*NUM_CH +: NUM_CH];
            end
        end
    end

    always_comb begin
        presc_d     = presc_q;
        phase_d     = phase_q;
        pwm_d       = pwm_q;
        cyc_d       = cyc_q;
        mode_hist_d = mode_i;

        if (!active || mode_change) begin
            presc_d = '0;
            phase_d = '0;
            pwm_d   = '0;
            cyc_d   = '0;
        end else begin
            pwm_d   = pwm_q + 1'b1;
            presc_d = presc_done ? '0 : presc_q + 1'b1;
            // Solid mode lets the prescaler run but freezes phase and cycle count
            if (step_tick && breathe) begin
                phase_d = phase_q + 1'b1;
                if (phase_wrap) begin
                    cyc_d = group_done ? '0 : cyc_q + 1'b1;
                end
            end
        end

        idx_d = idx_q;
        if (group_done) begin
            idx_d = (idx_q == IDX_LAST) ? 4'd0 : idx_q + 4'd1;
        end
        adv_d = group_done;
        led_d = active ? (pattern_bits & {NUM_CH{pwm_on}}) : '0;
    end

    always_ff @(posedge Sys_Clk0 or negedge Sys_Clk0_Rst_n) begin
        if (!Sys_Clk0_Rst_n) begin
            presc_q     <= '0;
            phase_q     <= '0;
            pwm_q       <= '0;
            cyc_q       <= '0;
            idx_q       <= '0;
            mode_hist_q <= '0;
            led_q       <= '0;
            adv_q       <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            phase_q     <= phase_d;
            pwm_q       <= pwm_d;
            cyc_q       <= cyc_d;
            idx_q       <= idx_d;
            mode_hist_q <= mode_hist_d;
            led_q       <= led_d;
            adv_q       <= adv_d;
        end
    end

    // level_o follows duty combinationally, so it is gated to read 0 while reset is held
    assign level_o       = Sys_Clk0_Rst_n ? duty : '0;
    assign led_o         = led_q;
    assign pattern_idx_o = idx_q;
    assign pattern_adv_o = adv_q;

endmodule

// File: tb/tb_breathe_sequencer.sv
// tb/tb_breathe_sequencer.sv - scoreboard bench for breathe_sequencer against a step-counting reference model
module tb_breathe_sequencer;

    localparam int NUM_CH       = 3;
    localparam int PWM_BITS     = 2;
    localparam int PERIOD_W     = 24;
    localparam int NUM_PATTERNS = 6;
    localparam int CPP          = 2;
    localparam int SPAN         = 2 ** (PWM_BITS + 1);
    localparam int PWM_SPAN     = 2 ** PWM_BITS;

    logic [17:0] pat_table = 18'b110_101_011_001_010_100;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                enable_i = 1'b0;
    logic [1:0]          mode_i = 2'b00;
    logic [PERIOD_W-1:0] period_i = '0;
    logic [PWM_BITS-1:0] brightness_i = '0;
    logic [NUM_CH-1:0]   led_o;
    logic [PWM_BITS-1:0] level_o;
    logic [3:0]          pattern_idx_o;
    logic                pattern_adv_o;

    breathe_sequencer #(
        .NUM_CH(NUM_CH), .PWM_BITS(PWM_BITS), .PERIOD_W(PERIOD_W),
        .NUM_PATTERNS(NUM_PATTERNS), .CYCLES_PER_PATTERN(CPP)
    ) dut (
        .Sys_Clk0(clk), .Sys_Clk0_Rst_n(rst_n), .enable_i(enable_i), .mode_i(mode_i),
        .period_i(period_i), .brightness_i(brightness_i), .led_o(led_o), .level_o(level_o),
        .pattern_idx_o(pattern_idx_o), .pattern_adv_o(pattern_adv_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] led;
        logic [1:0] level;
        logic [3:0] idx;
        logic       adv;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: run length, clocks into current step, steps taken in this run
    int         m_run_clk, m_in_step, m_steps, m_idx;
    logic [1:0] m_prev_mode;
    logic [2:0] m_led;
    logic       m_adv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    function automatic int breathe_level(input int steps);
        int p;
        p = steps % SPAN;
        return (p < SPAN / 2) ? p : SPAN - 1 - p;
    endfunction

    task automatic model_reset();
        m_run_clk = 0; m_in_step = 0; m_steps = 0; m_idx = 0;
        m_prev_mode = 2'b00; m_led = 3'b000; m_adv = 1'b0;
    endtask

    task automatic step(input logic en, input logic [1:0] md, input logic [PERIOD_W-1:0] per,
                        input logic [PWM_BITS-1:0] br);
        bit         act;
        int         duty, per_eff;
        logic [2:0] row;
        exp_t       e;
        enable_i = en; mode_i = md; period_i = per; brightness_i = br;
        act  = en && (md == 2'b01 || md == 2'b10);
        duty = !act ? 0 : (md == 2'b10) ? breathe_level(m_steps) : int'(br);
        e.led = m_led; e.level = 2'(duty); e.idx = 4'(m_idx); e.adv = m_adv;
        exp_q.push_back(e);

        row   = pat_table[m_idx*3 +: 3];
        m_led = (act && (m_run_clk % PWM_SPAN) < duty) ? row : 3'b000;
        m_adv = 1'b0;
        if (!act || md != m_prev_mode) begin
            m_run_clk = 0; m_in_step = 0; m_steps = 0;
        end else begin
            per_eff = (per == 0) ? 1 : int'(per);
            m_run_clk++;
            if (m_in_step + 1 >= per_eff) begin
                m_in_step = 0;
                if (md == 2'b10) begin
                    m_steps++;
                    if (m_steps % (SPAN * CPP) == 0) begin
                        m_idx = (m_idx + 1) % NUM_PATTERNS;
                        m_adv = 1'b1;
                    end
                end
            end else begin
                m_in_step++;
            end
        end
        m_prev_mode = md;
    endtask

    task automatic cycle(input logic en, input logic [1:0] md, input logic [PERIOD_W-1:0] per,
                         input logic [PWM_BITS-1:0] br);
        @(posedge clk); #1;
        step(en, md, per, br);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_led"},   32'(led_o),         0);
        check({tag, "_level"}, 32'(level_o),       0);
        check({tag, "_idx"},   32'(pattern_idx_o), 0);
        check({tag, "_adv"},   32'(pattern_adv_o), 0);
    endtask

    task automatic do_reset(input logic en, input logic [1:0] md, input logic [PERIOD_W-1:0] per,
                            input logic [PWM_BITS-1:0] br);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        step(en, md, per, br);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("outputs{led,level,idx,adv}",
                  32'({led_o, level_o, pattern_idx_o, pattern_adv_o}), 32'(mon_e));
        end
    end

    initial begin
        model_reset();
        #2;
        check_reset_outputs("por");
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'b0, 2'b10, 24'd3, 2'd0);

        repeat (5)   cycle(1'b0, 2'b10, 24'd3, 2'd0);
        repeat (300) cycle(1'b1, 2'b10, 24'd3, 2'd0);

        repeat (20) cycle(1'b1, 2'b01, 24'd3, 2'd2);
        repeat (12) cycle(1'b1, 2'b01, 24'd3, 2'd0);

        repeat (20) cycle(1'b1, 2'b10, 24'd0, 2'd0);

        cycle(1'b0, 2'b10, 24'd10, 2'd0);
        repeat (6)  cycle(1'b1, 2'b10, 24'd10, 2'd0);
        repeat (10) cycle(1'b1, 2'b10, 24'd2, 2'd0);

        repeat (5)  cycle(1'b0, 2'b10, 24'd3, 2'd0);
        repeat (29) cycle(1'b1, 2'b10, 24'd3, 2'd0);
        cycle(1'b1, 2'b01, 24'd3, 2'd3);
        repeat (8)  cycle(1'b1, 2'b01, 24'd3, 2'd3);

        for (int i = 0; i < 2000 && m_idx != 3; i++) begin
            cycle(1'b1, 2'b10, 24'd1, 2'd0);
        end
        do_reset(1'b1, 2'b10, 24'd3, 2'd0);
        repeat (40) cycle(1'b1, 2'b10, 24'd3, 2'd0);

        for (int seg = 0; seg < 120; seg++) begin
            logic                en;
            logic [1:0]          md;
            logic [PERIOD_W-1:0] per;
            logic [PWM_BITS-1:0] br;
            int                  len;
            en  = ($urandom_range(0, 3) != 0);
            md  = 2'($urandom_range(0, 3));
            per = PERIOD_W'($urandom_range(0, 4));
            br  = PWM_BITS'($urandom);
            len = $urandom_range(1, 40);
            repeat (len) cycle(en, md, per, br);
        end

        @(negedge clk); #1;
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/breathe_sequencer.md
BREATHE_SEQUENCER -- requirements
Module: breathe_sequencer

Interface
REQ-001 Parameter NUM_CH, default 3: number of LED channels; bit 0 = red, bit 1 = green, bit 2 = blue.
REQ-002 Parameter PWM_BITS, default 8: PWM and brightness resolution in bits.
REQ-003 Parameter PERIOD_W, default 24: width of period_i.
REQ-004 Parameter NUM_PATTERNS, default 6: number of entries in the colour pattern table; legal range 1..16.
REQ-005 Parameter PATTERN_TABLE, width NUM_CH*NUM_PATTERNS, default {110,101,011,001,010,100}: entry k occupies bits [k*NUM_CH +: NUM_CH]; a 1 bit enables that channel.
REQ-006 Parameter CYCLES_PER_PATTERN, default 2: number of complete breathe cycles per pattern entry; legal range >= 1.
REQ-007 Sys_Clk0  input  1  sole clock; all state changes on its rising edge.
REQ-008 Sys_Clk0_Rst_n  input  1  asynchronous, active-low reset.
REQ-009 enable_i  input  1  run enable; level-sensitive.
REQ-010 mode_i  input  2  operating mode: 00 off, 01 solid, 10 breathe, 11 treated as off.
REQ-011 period_i  input  PERIOD_W  number of clocks per brightness step; 0 is treated as 1.
REQ-012 brightness_i  input  PWM_BITS  duty value used in solid mode.
REQ-013 led_o  output  NUM_CH  registered channel drive; 1 = LED on.
REQ-014 level_o  output  PWM_BITS  current duty value.
REQ-015 pattern_idx_o  output  4  index of the current pattern entry.
REQ-016 pattern_adv_o  output  1  one-clock pulse on each pattern advance.

Function
REQ-017 Run condition: active = enable_i & (mode_i == 01 or mode_i == 10).
REQ-018 Prescaler: counts 0 up to (max(period_i,1) - 1).
  - Comparison uses >=, so lowering period_i mid-step ends the step on the next clock.
  - step_tick is asserted for the single clock in which the prescaler wraps to 0.
REQ-019 Phase counter: PWM_BITS+1 bits wide; increments on step_tick in breathe mode; wraps from 2^(PWM_BITS+1)-1 to 0.
  - The wrap is one complete breathe cycle.
REQ-020 Breathe level: equals phase[PWM_BITS-1:0] when phase MSB = 0, otherwise ~phase[PWM_BITS-1:0].
  - The resulting sequence is 0..max, max..0; each endpoint is held for two steps.
REQ-021 Duty selection: duty = level in breathe mode, brightness_i in solid mode, 0 otherwise.
  - level_o = duty.
REQ-022 PWM counter: PWM_BITS wide; free-running while active; pwm_on = (pwm_cnt < duty).
  - duty 0 gives always off.
  - duty max gives on for 2^PWM_BITS - 1 of every 2^PWM_BITS clocks.
REQ-023 Output: led_o[i] <= PATTERN_TABLE entry[pattern_idx][i] & pwm_on & active.
  - led_o is registered, one clock after pwm_cnt/duty.
REQ-024 Cycle counter: counts phase wraps in breathe mode.
  - On the wrap that brings it to CYCLES_PER_PATTERN, it clears to 0.
  - On that same clock, pattern_idx advances by 1 modulo NUM_PATTERNS and pattern_adv_o pulses for 1 clock.
REQ-025 Solid mode: phase, cycle counter and pattern_idx are held; no pattern advance occurs.
REQ-026 Mode change: any change of mode_i clears prescaler, phase, PWM counter and cycle counter on the next clock; pattern_idx is retained.
REQ-027 enable_i low: prescaler, phase, PWM counter and cycle counter are held at 0; pattern_idx is retained; led_o = 0 and pattern_adv_o = 0 from the next clock.
REQ-028 Restart: on enable_i rising, or entry into breathe mode, operation restarts from phase 0 and prescaler 0.
REQ-029 Simultaneous step_tick and mode change: the mode-change clear takes priority; no phase increment and no advance occur.
REQ-030 NUM_PATTERNS = 1: pattern_idx stays 0 and pattern_adv_o still pulses on each completed group of cycles.

Reset
REQ-031 Asserting Sys_Clk0_Rst_n low immediately forces all of the following to 0, independent of the clock:
  - led_o, level_o, pattern_idx_o, pattern_adv_o;
  - the prescaler, phase, PWM, cycle and mode-history registers.
REQ-032 After Sys_Clk0_Rst_n deasserts, the first state change occurs on the first rising edge of Sys_Clk0 that satisfies recovery timing.
REQ-033 Reset asserted mid-breathe or mid-pulse of pattern_adv_o truncates the operation; no partial state survives.

Verification
REQ-034 Breathe timing (PWM_BITS=2, period_i=3, mode 10, enable 1): level_o sequence is 0,1,2,3,3,2,1,0, each value held 3 clocks; phase wraps every 24 clocks.
REQ-035 Pattern advance (same setup, CYCLES_PER_PATTERN=2): pattern_adv_o first pulses 48 clocks after enable; pattern_idx_o steps 0->1.
  - After 6 advances, pattern_idx_o is back at 0.
REQ-036 Solid mode (mode 01, brightness_i=2, PWM_BITS=2): enabled led_o bits are high 2 of every 4 clocks; brightness_i=0 gives always low; pattern_idx_o is constant.
REQ-037 Period edge cases: period_i=0 gives level steps every clock; period_i lowered from 10 to 2 while the prescaler is at 5 gives step_tick on the next clock.
REQ-038 Disable and mode change: enable_i low for 5 clocks gives led_o=0 and pattern_idx retained; on re-enable level_o restarts at 0. A mode change coinciding with step_tick produces no advance.
REQ-039 Reset mid-operation: Sys_Clk0_Rst_n low at pattern_idx=3 immediately gives all outputs 0; after release with enable high, operation resumes from pattern_idx 0, level 0.
